// File: rtl/ascon_permutation_iter.sv
// ============================================================================
//  Module   : ascon_permutation_iter
//  Purpose  : Iterative Ascon permutation (pa/pb), UNROLL rounds per clock,
//             start/done handshake, registered 320-bit state.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ascon_pack;
    // Element [i] holds Ascon word xi.
    typedef logic [4:0][63:0] type_state;
endpackage

module ascon_permutation_iter #(
    parameter int UNROLL = 1
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    input  logic                  start_i,
    input  logic [1:0]            rounds_i,
    input  ascon_pack::type_state state_i,
    output ascon_pack::type_state state_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [3:0]            round_o
);

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_run  = 2'd1;
    localparam logic [1:0] c_done = 2'd2;

    localparam logic [3:0] c_step      = 4'(UNROLL);
    localparam logic [3:0] c_last_next = 4'd12;

    localparam logic [4:0] c_sbox [32] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
    };

    function automatic logic [63:0] ror(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    function automatic ascon_pack::type_state round_fn(
        input ascon_pack::type_state s,
        input logic [3:0]            r
    );
        ascon_pack::type_state t;
        ascon_pack::type_state u;
        ascon_pack::type_state o;
        logic [4:0]            col;
        logic [4:0]            sub;
        t = s;
        u = '0;
        t[2][7:0] = t[2][7:0] ^ {~r, r};
        // Bit-sliced S-box: one 5-bit column per bit position, x0 as MSB.
        for (int j = 0; j < 64; j++) begin
            col = {t[0][j], t[1][j], t[2][j], t[3][j], t[4][j]};
            sub = c_sbox[col];
            u[0][j] = sub[4];
            u[1][j] = sub[3];
            u[2][j] = sub[2];
            u[3][j] = sub[1];
            u[4][j] = sub[0];
        end
        o[0] = u[0] ^ ror(u[0], 19) ^ ror(u[0], 28);
        o[1] = u[1] ^ ror(u[1], 61) ^ ror(u[1], 39);
        o[2] = u[2] ^ ror(u[2], 1)  ^ ror(u[2], 6);
        o[3] = u[3] ^ ror(u[3], 10) ^ ror(u[3], 17);
        o[4] = u[4] ^ ror(u[4], 7)  ^ ror(u[4], 41);
        return o;
    endfunction

    logic [1:0]            r_fsm;
    ascon_pack::type_state r_state;
    logic                  r_busy;
    logic                  r_done;
    logic [3:0]            r_round;
    ascon_pack::type_state w_next;
    logic [3:0]            w_round_next;
    logic [3:0]            w_first;

    generate
        if (UNROLL == 1) begin : g_unroll1
            assign w_next = round_fn(r_state, r_round);
        end else if (UNROLL == 2) begin : g_unroll2
            // Start indices 0/4/6 are even, so the second round never passes 11.
            assign w_next = round_fn(round_fn(r_state, r_round), r_round + 4'd1);
        end else begin : g_bad_unroll
            $error("ascon_permutation_iter: UNROLL must be 1 or 2");
            assign w_next = r_state;
        end
    endgenerate

    assign w_round_next = r_round + c_step;

    always_comb begin
        w_first = 4'd0;
        case (rounds_i)
            2'b01:   w_first = 4'd4;
            2'b10:   w_first = 4'd6;
            default: w_first = 4'd0;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_fsm   <= c_idle;
            r_state <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_round <= 4'd0;
        end else begin
            case (r_fsm)
                c_idle: begin
                    if (start_i) begin
                        r_state <= state_i;
                        r_round <= w_first;
                        r_busy  <= 1'b1;
                        r_fsm   <= c_run;
                    end
                end
                c_run: begin
                    r_state <= w_next;
                    if (w_round_next == c_last_next) begin
                        r_round <= 4'd0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_fsm   <= c_done;
                    end else begin
                        r_round <= w_round_next;
                    end
                end
                c_done: begin
                    r_done <= 1'b0;
                    r_fsm  <= c_idle;
                end
                default: begin
                    r_busy <= 1'b0;
                    r_done <= 1'b0;
                    r_fsm  <= c_idle;
                end
            endcase
        end
    end

    assign state_o = r_state;
    assign busy_o  = r_busy;
    assign done_o  = r_done;
    assign round_o = r_round;

endmodule

`default_nettype wire

// File: tb/tb_ascon_permutation_iter.sv
// ============================================================================
//  Module   : tb_ascon_permutation_iter
//  Purpose  : Self-checking bench for ascon_permutation_iter, UNROLL=1 and 2.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ascon_permutation_iter;
    import ascon_pack::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start [2];
    logic [1:0] rsel  [2];
    type_state  sin   [2];
    type_state  sout  [2];
    logic       busy  [2];
    logic       done  [2];
    logic [3:0] rnd   [2];

    int tests = 0;
    int fails = 0;

    type_state in6, in8, res12, res8, res6;

    ascon_permutation_iter #(.UNROLL(1)) dut1 (
        .clock_i(clk), .reset_i(rst), .start_i(start[0]), .rounds_i(rsel[0]),
        .state_i(sin[0]), .state_o(sout[0]), .busy_o(busy[0]), .done_o(done[0]),
        .round_o(rnd[0])
    );

    ascon_permutation_iter #(.UNROLL(2)) dut2 (
        .clock_i(clk), .reset_i(rst), .start_i(start[1]), .rounds_i(rsel[1]),
        .state_i(sin[1]), .state_o(sout[1]), .busy_o(busy[1]), .done_o(done[1]),
        .round_o(rnd[1])
    );

    // ---------------- reference model ----------------
    int sbox_tab [32] = '{
        'h04, 'h0b, 'h1f, 'h14, 'h1a, 'h15, 'h09, 'h02,
        'h1b, 'h05, 'h08, 'h12, 'h1d, 'h03, 'h06, 'h1c,
        'h1e, 'h13, 'h07, 'h0e, 'h00, 'h0d, 'h11, 'h18,
        'h10, 'h0c, 'h01, 'h19, 'h16, 'h0a, 'h0f, 'h17
    };
    int rot_a [5] = '{19, 61, 1, 10, 7};
    int rot_b [5] = '{28, 39, 6, 17, 41};

    function automatic int n_of(input logic [1:0] r);
        case (r)
            2'b01:   return 8;
            2'b10:   return 6;
            default: return 12;
        endcase
    endfunction

    function automatic logic [63:0] rotr(input logic [63:0] w, input int a);
        logic [127:0] d;
        d = {w, w};
        return d[a +: 64];
    endfunction

    function automatic type_state model_perm(input type_state s, input int n);
        logic [63:0] x [5];
        logic [63:0] y [5];
        int          v, o;
        type_state   res;
        for (int i = 0; i < 5; i++) x[i] = s[i];
        for (int r = 12 - n; r < 12; r++) begin
            x[2] = x[2] ^ 64'((15 - r) * 16 + r);
            for (int i = 0; i < 5; i++) y[i] = '0;
            for (int j = 0; j < 64; j++) begin
                v = 0;
                for (int i = 0; i < 5; i++) v = v * 2 + int'(x[i][j]);
                o = sbox_tab[v];
                for (int i = 0; i < 5; i++) y[i][j] = o[4 - i];
            end
            for (int i = 0; i < 5; i++)
                x[i] = y[i] ^ rotr(y[i], rot_a[i]) ^ rotr(y[i], rot_b[i]);
        end
        for (int i = 0; i < 5; i++) res[i] = x[i];
        return res;
    endfunction

    function automatic type_state rand_state();
        type_state s;
        for (int i = 0; i < 5; i++) s[i] = {$urandom, $urandom};
        return s;
    endfunction

    // ---------------- scenario tasks ----------------
    task automatic run_perm(input int u, input logic [1:0] rs, input type_state s,
                            input bit inject, output type_state res);
        int        n, unr, first, k;
        type_state exp_s;
        n     = n_of(rs);
        unr   = u + 1;
        first = 12 - n;
        exp_s = model_perm(s, n);
        sin[u] = s; rsel[u] = rs; start[u] = 1'b1;
        @(posedge clk); #1;
        start[u] = 1'b0;
        tests++;
        if (busy[u] !== 1'b1 || rnd[u] !== 4'(first)) begin
            fails++;
            $display("FAIL accept u=%0d: busy=%b round=%0d, required busy=1 round=%0d", u, busy[u], rnd[u], first);
        end
        tests++;
        if (sout[u] !== s) begin
            fails++;
            $display("FAIL capture u=%0d: got %h required %h", u, sout[u], s);
        end
        k = 0;
        while (done[u] !== 1'b1 && k < 20) begin
            tests++;
            if (rnd[u] !== 4'(first + k * unr)) begin
                fails++;
                $display("FAIL round_seq u=%0d k=%0d: got %0d required %0d", u, k, rnd[u], first + k * unr);
            end
            if (inject && k == 1) begin
                start[u] = 1'b1; sin[u] = ~s; rsel[u] = 2'b10;
            end
            @(posedge clk); #1;
            start[u] = 1'b0;
            k++;
        end
        tests++;
        if (k !== n / unr) begin
            fails++;
            $display("FAIL latency u=%0d n=%0d: got %0d RUN edges required %0d", u, n, k, n / unr);
        end
        res = sout[u];
        tests++;
        if (sout[u] !== exp_s) begin
            fails++;
            $display("FAIL result u=%0d n=%0d: got %h required %h", u, n, sout[u], exp_s);
        end
        tests++;
        if (busy[u] !== 1'b0 || rnd[u] !== 4'd0) begin
            fails++;
            $display("FAIL done_flags u=%0d: busy=%b round=%0d required 0/0", u, busy[u], rnd[u]);
        end
        if (inject) begin
            start[u] = 1'b1; sin[u] = ~s; rsel[u] = 2'b10;
        end
        @(posedge clk); #1;
        start[u] = 1'b0;
        tests++;
        if (done[u] !== 1'b0 || busy[u] !== 1'b0 || sout[u] !== exp_s) begin
            fails++;
            $display("FAIL done_pulse u=%0d: done=%b busy=%b state=%h", u, done[u], busy[u], sout[u]);
        end
        @(posedge clk); #1;
        tests++;
        if (busy[u] !== 1'b0 || sout[u] !== exp_s) begin
            fails++;
            $display("FAIL hold u=%0d: busy=%b state=%h required busy=0 state=%h", u, busy[u], sout[u], exp_s);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int u = 0; u < 2; u++) begin
            tests++;
            if (sout[u] !== '0 || busy[u] !== 1'b0 || done[u] !== 1'b0 || rnd[u] !== 4'd0) begin
                fails++;
                $display("FAIL reset u=%0d: state=%h busy=%b done=%b round=%0d, required all 0", u, sout[u], busy[u], done[u], rnd[u]);
            end
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_run();
        bit        seen;
        type_state r;
        sin[0] = rand_state(); rsel[0] = 2'b00; start[0] = 1'b1;
        @(posedge clk); #1;
        start[0] = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        tests++;
        if (busy[0] !== 1'b1 || rnd[0] !== 4'd4) begin
            fails++;
            $display("FAIL pre_abort: busy=%b round=%0d required 1/4", busy[0], rnd[0]);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        tests++;
        if (sout[0] !== '0 || busy[0] !== 1'b0 || rnd[0] !== 4'd0 || done[0] !== 1'b0) begin
            fails++;
            $display("FAIL abort: state=%h busy=%b round=%0d done=%b required zeros", sout[0], busy[0], rnd[0], done[0]);
        end
        seen = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            if (done[0] === 1'b1 || busy[0] === 1'b1) seen = 1'b1;
        end
        tests++;
        if (seen !== 1'b0) begin
            fails++;
            $display("FAIL abort_quiet: activity seen=%b required 0", seen);
        end
        run_perm(0, 2'b00, rand_state(), 1'b0, r);
    endtask

    task automatic test_rounds_u1();
        run_perm(0, 2'b00, '0, 1'b0, res12);
        in6 = rand_state();
        run_perm(0, 2'b10, in6, 1'b0, res6);
        in8 = rand_state();
        run_perm(0, 2'b01, in8, 1'b0, res8);
    endtask

    task automatic test_unroll2();
        type_state r;
        run_perm(1, 2'b00, '0, 1'b0, r);
        tests++;
        if (r !== res12) begin fails++; $display("FAIL u2_vs_u1_p12: got %h required %h", r, res12); end
        run_perm(1, 2'b01, in8, 1'b0, r);
        tests++;
        if (r !== res8) begin fails++; $display("FAIL u2_vs_u1_p8: got %h required %h", r, res8); end
        run_perm(1, 2'b10, in6, 1'b0, r);
        tests++;
        if (r !== res6) begin fails++; $display("FAIL u2_vs_u1_p6: got %h required %h", r, res6); end
    endtask

    task automatic test_ignored_inputs();
        type_state r;
        run_perm(0, 2'b00, rand_state(), 1'b1, r);
        run_perm(1, 2'b01, rand_state(), 1'b1, r);
        run_perm(0, 2'b11, rand_state(), 1'b1, r);
    endtask

    task automatic test_back_to_back(input int u);
        type_state  q_exp [$];
        type_state  cur_s, got;
        logic [1:0] cur_r;
        int         cyc, last_acc, last_n, ndone, unr;
        logic       prev_busy;
        unr = u + 1;
        cur_s = rand_state(); cur_r = 2'($urandom_range(0, 3));
        sin[u] = cur_s; rsel[u] = cur_r; start[u] = 1'b1;
        prev_busy = 1'b0; last_acc = -1; last_n = 0; ndone = 0; cyc = 0;
        while (ndone < 1000 && cyc < 30000) begin
            @(posedge clk); #1;
            cyc++;
            if (busy[u] === 1'b1 && prev_busy === 1'b0) begin
                if (last_acc >= 0) begin
                    tests++;
                    if (cyc - last_acc !== last_n / unr + 2) begin
                        fails++;
                        $display("FAIL b2b_period u=%0d: got %0d cycles required %0d", u, cyc - last_acc, last_n / unr + 2);
                    end
                end
                last_acc = cyc;
                last_n = n_of(cur_r);
                q_exp.push_back(model_perm(cur_s, last_n));
                cur_s = rand_state(); cur_r = 2'($urandom_range(0, 3));
                sin[u] = cur_s; rsel[u] = cur_r;
            end
            if (done[u] === 1'b1) begin
                ndone++;
                tests++;
                if (q_exp.size() == 0) begin
                    fails++;
                    $display("FAIL b2b_spurious u=%0d: done with no pending start", u);
                end else begin
                    got = q_exp.pop_front();
                    if (sout[u] !== got) begin
                        fails++;
                        $display("FAIL b2b_result u=%0d #%0d: got %h required %h", u, ndone, sout[u], got);
                    end
                end
            end
            prev_busy = busy[u];
        end
        start[u] = 1'b0;
        tests++;
        if (ndone !== 1000) begin
            fails++;
            $display("FAIL b2b_timeout u=%0d: got %0d results required 1000", u, ndone);
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        for (int u = 0; u < 2; u++) begin
            start[u] = 1'b0; rsel[u] = 2'b00; sin[u] = '0;
        end
        test_reset();
        test_reset_mid_run();
        test_rounds_u1();
        test_unroll2();
        test_ignored_inputs();
        test_back_to_back(0);
        test_back_to_back(1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
